// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//
// Hardwired control unit for data_path. It fetches one instruction and then
// runs a register-register ALU operation. Each state drives the strobes for
// exactly one bus transfer:
//   IDLE -> T0 -> T1 (held while memory is not ready) -> T2 -> T3 -> T4 -> T5
//   [-> T6 for mul/div] -> IDLE
// An illegal opcode is caught in T3, which then returns to IDLE.
//
// Optional feature macro: ALU_SEQ_MULDIV_EN
//   defined   : mul (01111) and div (10000) write LO in T5 and HI in T6.
//   undefined : mul and div are illegal opcodes. T6 is unreachable and
//               HIin/LOin stay 0.
//
// Ports
//   Clock       rising-edge clock
//   clear       asynchronous active-low reset
//   start       begin a fetch/execute while idle (ignored while busy)
//   mem_ready   memory data valid on Mdatain this cycle
//   IR[31:0]    instruction: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15]
//   busy        state is not IDLE
//   done        pulses in the last writeback state
//   illegal     pulses in T3 when the opcode is illegal
//   op[4:0]     ALU opcode; nonzero only in T4
//   PCout MARin IncPC PCin Read MDRin MDRout IRin     fetch strobes
//   Yin ZHighin Zlowin Zhighout Zlowout HIin LOin    execute strobes
//   Rout[15:0]  one-hot register-to-bus select
//   Rin[15:0]   one-hot register load select
// ---------------------------------------------------------------------------
module alu_sequencer (
  input  logic        Clock,
  input  logic        clear,
  input  logic        start,
  input  logic        mem_ready,
  input  logic [31:0] IR,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [4:0]  op,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        PCin,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        ZHighin,
  output logic        Zlowin,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        HIin,
  output logic        LOin,
  output logic [15:0] Rout,
  output logic [15:0] Rin
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_T3   = 3'd4,
    S_T4   = 3'd5,
    S_T5   = 3'd6,
    S_T6   = 3'd7
  } state_t;

  localparam logic [4:0] OPC_FIRST_LEGAL = 5'b00011;
  localparam logic [4:0] OPC_LAST_LEGAL  = 5'b10010;
  localparam logic [4:0] OPC_MUL         = 5'b01111;
  localparam logic [4:0] OPC_DIV         = 5'b10000;
  localparam logic [4:0] OPC_NEG         = 5'b10001;
  localparam logic [4:0] OPC_NOT         = 5'b10010;

  state_t state_q, state_d;
  // High once T1 has been occupied for at least one cycle, so PCin can be
  // limited to the first cycle of a memory wait.
  logic   t1_seen_q;

  // Instruction fields
  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       is_muldiv;
  logic       is_unary;
  logic       is_legal;

  assign opcode    = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign is_muldiv = (opcode == OPC_MUL) || (opcode == OPC_DIV);
  assign is_unary  = (opcode == OPC_NEG) || (opcode == OPC_NOT);

`ifdef ALU_SEQ_MULDIV_EN
  assign is_legal = (opcode >= OPC_FIRST_LEGAL) && (opcode <= OPC_LAST_LEGAL);
`else
  assign is_legal = (opcode >= OPC_FIRST_LEGAL) && (opcode <= OPC_LAST_LEGAL)
                    && !is_muldiv;
`endif

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   if (mem_ready) state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3:   state_d = is_legal ? S_T4 : S_IDLE;
      S_T4:   state_d = S_T5;
`ifdef ALU_SEQ_MULDIV_EN
      S_T5:   state_d = is_muldiv ? S_T6 : S_IDLE;
`else
      S_T5:   state_d = S_IDLE;
`endif
      S_T6:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state_q   <= S_IDLE;
      t1_seen_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      t1_seen_q <= (state_q == S_T1);
    end
  end

  // -------------------------------------------------------------------------
  // Moore output decode of state and IR
  // -------------------------------------------------------------------------
  always_comb begin
    busy     = (state_q != S_IDLE);
    done     = 1'b0;
    illegal  = 1'b0;
    op       = 5'd0;
    PCout    = 1'b0;
    MARin    = 1'b0;
    IncPC    = 1'b0;
    PCin     = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    ZHighin  = 1'b0;
    Zlowin   = 1'b0;
    Zhighout = 1'b0;
    Zlowout  = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    Rout     = 16'd0;
    Rin      = 16'd0;

    unique case (state_q)
      S_IDLE: ;
      S_T0: begin
        // PC to MAR while the ALU forms PC+1 into Z.
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        Zlowin = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = !t1_seen_q;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        Rout[rb] = 1'b1;
        Yin      = is_legal;
        illegal  = !is_legal;
      end
      S_T4: begin
        Rout[is_unary ? rb : rc] = 1'b1;
        ZHighin = 1'b1;
        Zlowin  = 1'b1;
        op      = opcode;
      end
      S_T5: begin
        Zlowout = 1'b1;
`ifdef ALU_SEQ_MULDIV_EN
        if (is_muldiv) begin
          LOin = 1'b1;
        end else begin
          Rin[ra] = 1'b1;
          done    = 1'b1;
        end
`else
        Rin[ra] = 1'b1;
        done    = 1'b1;
`endif
      end
      S_T6: begin
`ifdef ALU_SEQ_MULDIV_EN
        Zhighout = 1'b1;
        HIin     = 1'b1;
        done     = 1'b1;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
//
// Randomized self-checking bench for alu_sequencer. For every instruction a
// reference model lists the expected output vector of each cycle from the
// bus-transfer rules of the sequencer. The DUT outputs are sampled on the
// falling clock edge and compared cycle by cycle. Stray start pulses while
// busy, memory wait cycles, back-to-back instructions and a mid-instruction
// reset are exercised as well.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;

`ifdef ALU_SEQ_MULDIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif

  typedef struct packed {
    logic        busy, done, illegal;
    logic [4:0]  op;
    logic        pcout, marin, incpc, pcin, read, mdrin, mdrout, irin;
    logic        yin, zhighin, zlowin, zhighout, zlowout, hiin, loin;
    logic [15:0] rout, rin;
  } outs_t;

  logic        Clock = 1'b0;
  logic        clear, start, mem_ready;
  logic [31:0] IR;
  logic        busy, done, illegal;
  logic [4:0]  op;
  logic        PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
  logic        Yin, ZHighin, Zlowin, Zhighout, Zlowout, HIin, LOin;
  logic [15:0] Rout, Rin;

  outs_t obs;
  outs_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    txn = 0;

  alu_sequencer dut (
    .Clock(Clock), .clear(clear), .start(start), .mem_ready(mem_ready),
    .IR(IR), .busy(busy), .done(done), .illegal(illegal), .op(op),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
    .ZHighin(ZHighin), .Zlowin(Zlowin), .Zhighout(Zhighout),
    .Zlowout(Zlowout), .HIin(HIin), .LOin(LOin), .Rout(Rout), .Rin(Rin)
  );

  always #5 Clock = ~Clock;

  assign obs = {busy, done, illegal, op, PCout, MARin, IncPC, PCin, Read,
                MDRin, MDRout, IRin, Yin, ZHighin, Zlowin, Zhighout, Zlowout,
                HIin, LOin, Rout, Rin};

  task automatic check(input string tag, input outs_t got, input outs_t want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Reference model: the list of per-cycle outputs for one instruction,
  // from the start edge up to the final state.
  task automatic build_exp(input logic [31:0] ir, input int waits);
    outs_t o;
    int    opc, ra, rb, rc;
    bit    legal, md, unary;
    opc   = int'(ir[31:27]);
    ra    = int'(ir[26:23]);
    rb    = int'(ir[22:19]);
    rc    = int'(ir[18:15]);
    md    = (opc == 15) || (opc == 16);
    unary = (opc == 17) || (opc == 18);
    legal = (opc >= 3) && (opc <= 18) && (MULDIV || !md);
    exp_q.delete();
    // fetch: PC -> MAR, PC+1 -> Z
    o = '0; o.busy = 1; o.pcout = 1; o.marin = 1; o.incpc = 1; o.zlowin = 1;
    exp_q.push_back(o);
    // memory read, PC update only on the first cycle
    for (int i = 0; i <= waits; i++) begin
      o = '0; o.busy = 1; o.zlowout = 1; o.read = 1; o.mdrin = 1;
      o.pcin = (i == 0);
      exp_q.push_back(o);
    end
    o = '0; o.busy = 1; o.mdrout = 1; o.irin = 1;
    exp_q.push_back(o);
    // Rb -> Y, or illegal trap
    o = '0; o.busy = 1; o.rout = 16'd1 << rb; o.yin = legal; o.illegal = !legal;
    exp_q.push_back(o);
    if (!legal) return;
    o = '0; o.busy = 1; o.rout = 16'd1 << (unary ? rb : rc);
    o.zhighin = 1; o.zlowin = 1; o.op = ir[31:27];
    exp_q.push_back(o);
    if (md) begin
      o = '0; o.busy = 1; o.zlowout = 1; o.loin = 1;
      exp_q.push_back(o);
      o = '0; o.busy = 1; o.zhighout = 1; o.hiin = 1; o.done = 1;
      exp_q.push_back(o);
    end else begin
      o = '0; o.busy = 1; o.zlowout = 1; o.rin = 16'd1 << ra; o.done = 1;
      exp_q.push_back(o);
    end
  endtask

  // Runs one instruction starting from IDLE just after a falling edge, then
  // checks the single IDLE cycle that follows it.
  task automatic run_op(input logic [31:0] ir, input int waits);
    int n;
    txn++;
    build_exp(ir, waits);
    n = exp_q.size();
    IR        = ir;
    start     = 1'b1;
    mem_ready = 1'($urandom);
    for (int k = 0; k < n; k++) begin
      @(negedge Clock);
      check($sformatf("t%0d_c%0d", txn, k), obs, exp_q[k]);
      // stray start pulses while busy must be ignored
      start = (k == n - 1) ? 1'b0 : 1'($urandom);
      if (k >= 1 && k <= waits) mem_ready = 1'b0;
      else if (k == waits + 1)  mem_ready = 1'b1;
      else                      mem_ready = 1'($urandom);
    end
    @(negedge Clock);
    check($sformatf("t%0d_idle", txn), obs, outs_t'(0));
  endtask

  task automatic reset_mid_op();
    txn++;
    build_exp(32'h18918000, 0);
    IR        = 32'h18918000;
    start     = 1'b1;
    mem_ready = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      @(negedge Clock);
      start = 1'b0;
    end
    check("rst_in_t4", obs, exp_q[4]);
    #1 clear = 1'b0;
    #1 check("rst_async", obs, outs_t'(0));
    @(negedge Clock);
    check("rst_held", obs, outs_t'(0));
    clear = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      check($sformatf("rst_idle%0d", k), obs, outs_t'(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear     = 1'b0;
    start     = 1'b0;
    mem_ready = 1'b0;
    IR        = 32'h0;
    repeat (2) @(negedge Clock);
    check("reset", obs, outs_t'(0));
    clear = 1'b1;
    @(negedge Clock);
    check("idle_no_start", obs, outs_t'(0));

    run_op(32'h18918000, 0);                                    // add R1,R2,R3
    run_op(32'h18918000, 3);                                    // memory wait
    run_op({5'b01111, 4'd2, 4'd4, 4'd5, 15'h1234}, 0);          // mul
    run_op({5'b10000, 4'd9, 4'd0, 4'd15, 15'h0}, 1);            // div
    run_op({5'b11111, 4'd3, 4'd8, 4'd1, 15'h0}, 0);             // illegal
    run_op({5'b01111, 4'd1, 4'd2, 4'd3, 15'h0}, 0);             // mul/illegal
    run_op({5'b10010, 4'd6, 4'd7, 4'd0, 15'h0}, 0);             // not
    run_op({5'b10001, 4'd0, 4'd15, 4'd4, 15'h0}, 2);            // neg into R0
    run_op({5'b00010, 4'd5, 4'd5, 4'd5, 15'h0}, 0);             // below legal
    run_op({5'b10011, 4'd5, 4'd5, 4'd5, 15'h0}, 0);             // above legal
    run_op({5'b00011, 4'd15, 4'd14, 4'd13, 15'h7fff}, 0);       // lowest legal

    for (int i = 0; i < 40; i++)
      run_op($urandom, int'($urandom_range(0, 3)));

    reset_mid_op();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
